fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end for the 5-stage RISC-V pipeline, sitting directly upstream of the IF/ID register.
- Issues in-order read requests to a latency-decoupled instruction memory and buffers the returned instructions, each tagged with its PC, in a small queue.
- Presents the queue head to IF/ID, honours the hazard-unit stall, and flushes on a taken branch or jump redirect from EX.

Parameters:
- PC_W, 9, program counter / instruction address width
- INS_W, 32, instruction width
- DEPTH, 4, queue entries; also the cap on queued plus in-flight fetches (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid this cycle; the memory accepts every asserted request
- imem_addr  out  PC_W  fetch address, valid when imem_req=1
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after the request
- imem_rdata  in  INS_W  response instruction
- stall  in  1  hold the current head (hazard-unit Reg_Stall)
- redirect  in  1  flush and refetch (branch-unit PcSel)
- redirect_pc  in  PC_W  target PC when redirect=1
- if_valid  out  1  head entry valid
- if_pc  out  PC_W  PC of head entry
- if_instr  out  INS_W  head instruction

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=0, resp_pc=0, count=0, outstanding=0, discard=0, queue pointers=0.
  - Outputs: imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0.
  - Reset asserted mid-operation drops all queued and in-flight state; responses arriving during reset are ignored.
- Issue:
  - imem_req = !redirect && (count + outstanding < DEPTH).
  - imem_addr = fetch_pc (combinational from the register).
  - On issue: fetch_pc += 4, modulo 2^PC_W (wraps 0x1FC -> 0x000 at PC_W=9); outstanding += 1.
- Response:
  - When imem_rvalid=1, outstanding -= 1.
  - If discard>0, the response is dropped and discard -= 1.
  - Otherwise {resp_pc, imem_rdata} is pushed and resp_pc += 4 (mod 2^PC_W).
  - The credit rule guarantees no push into a full queue; a push while full is an assertion failure.
- Output / pop:
  - if_valid = (count != 0); if_pc and if_instr come combinationally from the head entry.
  - When count=0, if_pc and if_instr hold the last head value and are don't-care.
  - Pop when if_valid && !stall && !redirect.
  - A simultaneous push and pop leaves count unchanged; pop on empty is impossible.
- Redirect (highest priority after reset):
  - Next edge: count=0, pointers reset, fetch_pc=redirect_pc, resp_pc=redirect_pc.
  - discard = outstanding − imem_rvalid; a response arriving in the redirect cycle is itself dropped.
  - No request and no pop occur in the redirect cycle; issue restarts the following cycle from redirect_pc.
  - if_valid=0 the cycle after a redirect, at the earliest until the first post-redirect response is pushed.
- Stall and redirect asserted together: redirect wins.
- Stall does not block issue or responses; the queue fills to DEPTH and then imem_req drops.
- Latency:
  - Redirect asserted at edge N, memory latency L: request for redirect_pc at N+1, push at N+1+L, if_valid=1 from N+1+L.
  - Steady state with L=1 and no stall: one instruction per cycle after a 2-cycle fill.
- Widths: count and outstanding are clog2(DEPTH+1) bits; discard has the same width.

Decomposition:
- Pipe_Buf_Reg_PKG gains:
  - typedef fq_entry_t {logic [PC_W-1:0] pc; logic [INS_W-1:0] instr;}
  - localparam PC_STEP=4
- Sub-module fetch_fifo holds the storage, read/write pointers, count, and full/empty flags.
- fetch_queue keeps the issue credit logic, the discard counter, and PC tracking.

Test Plan:
1. Reset release, L=1, memory holds instr=0x00000013+addr, no stall -> first imem_req addr 0x000 at cycle 0; if_valid from cycle 2 with pc 0x000, 0x004, 0x008 on consecutive cycles.
2. Hold stall=1 for 10 cycles, L=1 -> exactly 4 requests (0x000..0x00C); imem_req=0 thereafter; if_pc stays 0x000; release stall -> 0x000, 0x004, 0x008, 0x00C, then 0x010 delivered in order with no gaps.
3. L=3 with 3 fetches in flight, redirect=1 with redirect_pc=0x040 -> all 3 stale responses dropped; next request 0x040 one cycle later; first if_pc after redirect is 0x040.
4. Redirect in the same cycle as imem_rvalid=1 with stall=1 -> the arriving response is dropped, no pop occurs, count=0 the next cycle, discard = prior outstanding − 1.
5. redirect_pc=0x1F8, no stall -> delivered PCs 0x1F8, 0x1FC, 0x000, 0x004 (wrap-around).
6. Assert reset for 1 cycle with 2 queued and 2 in flight -> if_valid=0 and imem_req=0 immediately (asynchronous); after release, fetch restarts at 0x000 and late responses from before reset are not delivered.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared sizing constants and the queue entry type for the instruction-fetch front end.
package fetch_queue_pkg;

    localparam int PC_W    = 9;
    localparam int INS_W   = 32;
    localparam int DEPTH   = 4;
    localparam int PC_STEP = 4;

    // Occupancy-style counters must be able to represent DEPTH itself.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with count and full/empty flags.
// A flush empties the queue in one edge; its stale contents remain but are unreachable.
module fetch_fifo
    import fetch_queue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    output fq_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fq_entry_t        mem_q [DEPTH];

    // Next pointer and occupancy; flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: credit-limited in-order issue to instruction memory, PC tagging
// of responses, discard of stale responses after a redirect, and the IF/ID head.
module fetch_queue
    import fetch_queue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr
);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    fq_entry_t        head;
    fq_entry_t        push_data;
    logic [CNT_W:0]   credit_used;
    logic             issue;
    logic             push;
    logic             pop;

    // Queued plus in-flight fetches may never exceed DEPTH, so a response always has room.
    always_comb begin
        credit_used  = {1'b0, count} + {1'b0, outstanding_q};
        issue        = reset && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
        push         = imem_rvalid && !redirect && (discard_q == '0);
        pop          = !empty && !stall && !redirect;
        push_data.pc    = resp_pc_q;
        push_data.instr = imem_rdata;
    end

    // PC tracking and in-flight bookkeeping; a redirect marks everything in flight as stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            resp_pc_d     = redirect_pc;
            outstanding_d = outstanding_q - CNT_W'(imem_rvalid);
            discard_d     = outstanding_q - CNT_W'(imem_rvalid);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            if (push)  resp_pc_d  = resp_pc_q + PC_W'(PC_STEP);
            outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
            if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= '0;
            resp_pc_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign if_valid  = !empty;
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;

    push_into_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order fixed-latency instruction memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        if_valid;
    logic [8:0]  if_pc;
    logic [31:0] if_instr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] addr;
        int         due;
    } pend_t;

    pend_t pend[$];
    int    cyc = 0;
    int    lat = 1;

    typedef struct {
        logic       do_reset;
        int         lat;
        logic       stall;
        logic       redirect;
        logic [8:0] rpc;
        logic       exp_req;
        logic [8:0] exp_addr;
        logic       exp_valid;
        logic [8:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Memory response side: deliver the oldest request once its latency has elapsed.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h13 + 32'(pend[0].addr);
            pend.delete(0);
        end
    end

    // Memory request side: every asserted request is accepted.
    always @(negedge clk) begin
        if (imem_req) pend.push_back('{imem_addr, cyc + lat});
    end

    // The memory forgets in-flight requests when the system is reset.
    always @(negedge reset) begin
        pend.delete();
    end

    function automatic vec_t mkv(logic rst, int l, logic st, logic rd, logic [8:0] rpc,
                                 logic er, logic [8:0] ea, logic ev, logic [8:0] ep);
        vec_t v;
        v.do_reset = rst; v.lat = l; v.stall = st; v.redirect = rd; v.rpc = rpc;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [8:0] rpc);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic doReset(input int l);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        lat      = l;
        @(negedge clk);
    endtask

    task automatic checkHead(input string name, input logic [8:0] pc);
        checkOutput({name, "_valid"}, 32'(if_valid), 32'd1);
        checkOutput({name, "_pc"}, 32'(if_pc), 32'(pc));
        checkOutput({name, "_instr"}, if_instr, 32'h13 + 32'(pc));
    endtask

    initial begin
        #1 reset = 1'b0;

        // Reset state outputs.
        doReset(1);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_pc", 32'(if_pc), 32'd0);
        checkOutput("rst_instr", if_instr, 32'd0);

        // Cold start with latency 1: two-cycle fill, then one instruction per cycle.
        vecs.push_back(mkv(1, 1, 0, 0, 9'h000, 1, 9'h000, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h004, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h008, 1, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h00C, 1, 9'h004));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h010, 1, 9'h008));
        // Long stall: four fetches fill the queue, then issue stops until space frees.
        vecs.push_back(mkv(1, 1, 1, 0, 9'h000, 1, 9'h000, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 1, 0, 9'h000, 1, 9'h004, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 1, 0, 9'h000, 1, 9'h008, 1, 9'h000));
        vecs.push_back(mkv(0, 1, 1, 0, 9'h000, 1, 9'h00C, 1, 9'h000));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mkv(0, 1, 1, 0, 9'h000, 0, 9'h000, 1, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 0, 9'h000, 1, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h010, 1, 9'h004));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h014, 1, 9'h008));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h018, 1, 9'h00C));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h01C, 1, 9'h010));
        // Redirect near the top of the address space: PCs wrap to zero.
        vecs.push_back(mkv(1, 1, 0, 1, 9'h1F8, 0, 9'h000, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h1F8, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h1FC, 0, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h000, 1, 9'h1F8));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h004, 1, 9'h1FC));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h008, 1, 9'h000));
        vecs.push_back(mkv(0, 1, 0, 0, 9'h000, 1, 9'h00C, 1, 9'h004));

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) doReset(vecs[i].lat);
            applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            @(negedge clk);
            checkOutput($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                checkOutput($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("row%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("row%0d_pc", i), 32'(if_pc), 32'(vecs[i].exp_pc));
                checkOutput($sformatf("row%0d_instr", i), if_instr, 32'h13 + 32'(vecs[i].exp_pc));
            end
        end

        // Latency 3, redirect with three fetches in flight: all stale responses dropped.
        doReset(3);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 9'h000);
        applyStimulus(0, 1, 9'h040);
        @(negedge clk);
        checkOutput("t3_req_in_redirect", 32'(imem_req), 32'd0);
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkOutput("t3_req_after", 32'(imem_req), 32'd1);
        checkOutput("t3_addr_after", 32'(imem_addr), 32'h040);
        checkOutput("t3_valid_c4", 32'(if_valid), 32'd0);
        for (int c = 5; c < 8; c++) begin
            applyStimulus(0, 0, 9'h000);
            @(negedge clk);
            checkOutput($sformatf("t3_valid_c%0d", c), 32'(if_valid), 32'd0);
        end
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkHead("t3_first", 9'h040);
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkHead("t3_second", 9'h044);

        // Redirect coinciding with a response while stalled.
        doReset(2);
        for (int c = 0; c < 4; c++) applyStimulus(1, 0, 9'h000);
        @(negedge clk);
        checkHead("t4_pre", 9'h000);
        applyStimulus(1, 1, 9'h080);
        @(negedge clk);
        checkOutput("t4_req_in_redirect", 32'(imem_req), 32'd0);
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkOutput("t4_valid_after", 32'(if_valid), 32'd0);
        checkOutput("t4_discard", 32'(dut.discard_q), 32'd1);
        checkOutput("t4_outstanding", 32'(dut.outstanding_q), 32'd1);
        checkOutput("t4_addr_after", 32'(imem_addr), 32'h080);
        for (int c = 6; c < 8; c++) begin
            applyStimulus(0, 0, 9'h000);
            @(negedge clk);
            checkOutput($sformatf("t4_valid_c%0d", c), 32'(if_valid), 32'd0);
        end
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkHead("t4_first", 9'h080);

        // Reset mid-operation with two queued and two in flight.
        doReset(2);
        for (int c = 0; c < 4; c++) applyStimulus(1, 0, 9'h000);
        @(negedge clk);
        checkOutput("t6_queued_pre", 32'(if_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t6_valid_async", 32'(if_valid), 32'd0);
        checkOutput("t6_req_async", 32'(imem_req), 32'd0);
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkOutput("t6_req_restart", 32'(imem_req), 32'd1);
        checkOutput("t6_addr_restart", 32'(imem_addr), 32'h000);
        for (int c = 1; c < 3; c++) begin
            applyStimulus(0, 0, 9'h000);
            @(negedge clk);
            checkOutput($sformatf("t6_valid_n%0d", c), 32'(if_valid), 32'd0);
        end
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkHead("t6_first", 9'h000);
        applyStimulus(0, 0, 9'h000);
        @(negedge clk);
        checkHead("t6_second", 9'h004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
